// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 command transmitter: inhibits the bus, requests to send,
// then shifts one odd-parity byte out on device-generated clock falls.
module ps2_transmitter #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int FILTER_LEN     = 19,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  input  logic       kclk_i,
  input  logic       kdata_i,
  output logic       kclk_oe_o,
  output logic       kdata_oe_o
);

  localparam int FW   = $clog2(FILTER_LEN + 1);
  localparam int TMAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  // Index 0 is kclk, index 1 is kdata; filtered copies idle high like the bus.
  logic [1:0]    sync1_q;
  logic [1:0]    sync2_q;
  logic [1:0]    filt_q;
  logic [FW-1:0] fcnt_q [2];
  logic          kclk_dly_q;
  logic          fall;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      filt_q     <= 2'b11;
      kclk_dly_q <= 1'b1;
      for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
    end else begin
      sync1_q    <= {kdata_i, kclk_i};
      sync2_q    <= sync1_q;
      kclk_dly_q <= filt_q[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FW'(FILTER_LEN - 1)) begin
          filt_q[i] <= sync2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + FW'(1);
        end
      end
    end
  end

  assign fall = kclk_dly_q & ~filt_q[0];

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic          kdata_oe_q, kdata_oe_d;
  logic          framing;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      bit_cnt_q  <= '0;
      kdata_oe_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      bit_cnt_q  <= bit_cnt_d;
      kdata_oe_q <= kdata_oe_d;
    end
  end

  assign framing = (state_q == S_SEND) || (state_q == S_ACK) || (state_q == S_WAIT_IDLE);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    bit_cnt_d  = bit_cnt_q;
    kdata_oe_d = kdata_oe_q;
    done_o     = 1'b0;
    err_o      = 1'b0;

    if (framing && (timer_q != '0)) timer_d = timer_q - TW'(1);

    unique case (state_q)
      S_IDLE: begin
        if (tx_valid_i) begin
          shift_d  = tx_data_i;
          parity_d = ~^tx_data_i;
          timer_d  = TW'(INHIBIT_CYCLES - 1);
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (timer_q == '0) begin
          kdata_oe_d = 1'b1;
          state_d    = S_REQ;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_REQ: begin
        timer_d   = TW'(TIMEOUT_CYCLES);
        bit_cnt_d = '0;
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (fall) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q < 4'd8) begin
            kdata_oe_d = ~shift_q[bit_cnt_q[2:0]];
          end else if (bit_cnt_q == 4'd8) begin
            kdata_oe_d = ~parity_q;
          end else begin
            kdata_oe_d = 1'b0;
            state_d    = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (fall) begin
          if (!filt_q[1]) begin
            state_d = S_WAIT_IDLE;
          end else begin
            err_o   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (filt_q[0] && filt_q[1]) begin
          done_o  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A stalled device overrides whatever the frame logic decided this cycle.
    if (framing && (timer_q == '0)) begin
      done_o  = 1'b0;
      err_o   = 1'b1;
      state_d = S_IDLE;
    end

    if (state_d == S_IDLE) kdata_oe_d = 1'b0;
  end

  assign tx_ready_o = (state_q == S_IDLE);
  assign busy_o     = (state_q != S_IDLE);
  assign kclk_oe_o  = (state_q == S_INHIBIT) || (state_q == S_REQ);
  assign kdata_oe_o = kdata_oe_q;

endmodule

// File: doc/ps2_transmitter.md
# ps2_transmitter

Host-to-device PS/2 transmitter that sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard over the shared open-collector kclk/kdata lines. It is the opposite direction to the keyboard receive path and sits beside it in the keyboard subsystem. While a transfer is in progress it raises `busy`, so the top level can gate off the receive path and ignore the device-generated clocks. Line drivers are external tri-states controlled by the `*_oe` outputs (oe=1 pulls the line low, oe=0 releases it).

## Interface
- INHIBIT_CYCLES, 12000, cycles kclk is held low before the request (120 µs at 100 MHz).
- FILTER_LEN, 19, cycles a synchronized input must be stable before its filtered value changes.
- TIMEOUT_CYCLES, 2000000, maximum cycles from clock release to completion (20 ms).
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  8  byte to send; sampled on the accept cycle.
- tx_valid  in  1  send request.
- tx_ready  out  1  high only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on a successful, acknowledged transfer.
- err  out  1  one-cycle pulse on a missing ack or a timeout.
- kclk  in  1  PS/2 clock pin (asynchronous).
- kdata  in  1  PS/2 data pin (asynchronous).
- kclk_oe  out  1  1 drives kclk low.
- kdata_oe  out  1  1 drives kdata low.

## Operation
- Input conditioning:
  - kclk and kdata each pass through a 2-flop synchronizer, then a stability filter (FILTER_LEN).
  - A falling edge on the filtered kclk produces a one-cycle `fall` strobe.
- Accept: `tx_valid & tx_ready` on a rising clk edge latches `tx_data` into the shift register and latches parity = ~^tx_data (odd parity).
- States:
  - IDLE: kclk_oe=0, kdata_oe=0.
  - INHIBIT: kclk_oe=1 for exactly INHIBIT_CYCLES cycles, then go to REQ.
  - REQ: kclk_oe=1 and kdata_oe=1 (start bit) for exactly 1 cycle, then go to SEND.
  - SEND: kclk_oe=0. Bit counter n starts at 0. On each `fall`, kdata_oe is set as follows:
    - n=0..7: kdata_oe = ~data[n] (LSB first).
    - n=8: kdata_oe = ~parity.
    - n=9: kdata_oe = 0 (stop bit, line released); go to ACK.
  - ACK: on the next `fall`, sample filtered kdata. If it is 0 (device acknowledges), go to WAIT_IDLE; if it is 1, pulse err and go to IDLE.
  - WAIT_IDLE: wait until filtered kclk=1 and filtered kdata=1, then pulse done and go to IDLE.
- Timeout: a counter is cleared on entry to SEND and runs through WAIT_IDLE. On reaching TIMEOUT_CYCLES, release both lines, pulse err, go to IDLE.
- tx_valid while busy: ignored; no queueing.
- done and err are mutually exclusive and are never asserted while tx_ready=1 in the same cycle.

## Timing
- Reset values: state IDLE, kclk_oe=0, kdata_oe=0, done=0, err=0, busy=0, tx_ready=1, counters 0.
- Accept at edge k gives busy=1, tx_ready=0, kclk_oe=1 from cycle k+1.
- kdata_oe rises INHIBIT_CYCLES cycles after kclk_oe rises. kclk_oe falls 1 cycle after that.
- Data changes occur 2 + FILTER_LEN + 1 cycles after a pin falling edge. This is well inside the device's low phase (≥30 µs).
- After done or err, tx_ready=1 on the following cycle. Back-to-back transfers are allowed with no extra gap.
- rst asserted mid-frame: both oe outputs are 0 from the next edge, no done or err pulse, and the state returns to IDLE.
- A `fall` in INHIBIT or REQ (a device glitch) is ignored.

## Test plan
- Send 0xED with a device model clocking at 12.5 kHz that drives the ack. The model must sample data bits 1,0,1,1,0,1,1,1, parity=1, stop=1. Required: done pulses once, err=0, tx_ready returns to 1.
- Send 0x01: the model samples parity 0. Send 0x00: parity 1. Send 0xFF: parity 1. All three complete with done.
- Device model omits the ack (data left high on the 11th clock): err pulses exactly once, done never pulses, both oe=0.
- Device never clocks: err pulses exactly TIMEOUT_CYCLES cycles after kclk_oe falls, and the lines are released.
- Check INHIBIT width: kclk_oe high exactly INHIBIT_CYCLES cycles before kdata_oe rises. Hold tx_valid high with a new byte during busy: the second byte is not sent until after done.
- Assert rst at bit 4 of a frame: kclk_oe=kdata_oe=0 on the next cycle, tx_ready=1 after rst drops, and a fresh 0xF4 transfer then completes correctly.
